// File: rtl/cbs_pkg.sv
// Shared widths, data types and FSM encoding for the CBS line buffer.
package cbs_pkg;
    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 10;
    localparam int ROWS    = 3;
    localparam int ROW_W   = ROW_PIX * PIX_W;
    localparam int WIN_W   = ROWS * ROW_W;
    localparam int COL_W   = $clog2(ROW_PIX);

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [WIN_W-1:0] win_t;
    typedef logic [COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } lb_state_t;
endpackage

// File: rtl/cbs_row_shift.sv
// Serial-in/parallel-out row register: each load shifts one pixel in at the LSBs,
// so after a full row the first pixel sits at the MSBs. Clear wins over load.
module cbs_row_shift
    import cbs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  pix_t i_pix,
    output row_t o_row
);
    row_t r_row;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
        end else if (i_load) begin
            r_row <= {r_row[ROW_W-PIX_W-1:0], i_pix};
        end
    end

    assign o_row = r_row;
endmodule

// File: rtl/cbs_line_buffer.sv
// Packs a raster pixel stream into rows and emits a 3-row window per completed row
// once three rows are held; 1-cycle window latency, input stalls while a window waits.
module cbs_line_buffer
    import cbs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  pix_t pix_data,
    input  logic pix_valid,
    input  logic pix_last,
    output logic pix_ready,
    output win_t win_data,
    output logic win_valid,
    output logic win_last,
    input  logic win_ready,
    output logic frame_err
);
    lb_state_t r_state, w_state_nxt;
    col_t      r_col;
    row_t      r_mid, r_bot;
    row_t      w_shift_row, w_row_full;
    win_t      r_win_data;
    logic      r_win_valid, r_win_last, r_frame_err;
    logic      w_acc, w_col_end, w_complete, w_err, w_emit;

    assign pix_ready  = !r_win_valid || win_ready;
    assign w_acc      = pix_valid && pix_ready;
    assign w_col_end  = (r_col == col_t'(ROW_PIX - 1));
    assign w_complete = w_acc && w_col_end;
    assign w_err      = w_acc && pix_last && !w_col_end;

    cbs_row_shift u_row_shift (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_err),
        .i_load (w_acc),
        .i_pix  (pix_data),
        .o_row  (w_shift_row)
    );

    // The completing pixel is merged combinationally so the window sees the full row.
    assign w_row_full = {w_shift_row[ROW_W-PIX_W-1:0], pix_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
        end else if (w_acc) begin
            r_col <= (w_col_end || pix_last) ? '0 : r_col + col_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_err) begin
            w_state_nxt = FILL0;
        end else if (w_complete) begin
            if (pix_last) begin
                w_state_nxt = FILL0;
            end else begin
                case (r_state)
                    FILL0:   w_state_nxt = FILL1;
                    FILL1:   w_state_nxt = STREAM;
                    STREAM:  w_state_nxt = STREAM;
                    default: w_state_nxt = FILL0;
                endcase
            end
        end
    end

    always_comb begin
        w_emit = (r_state == STREAM) && w_complete;
    end

    // The oldest stored row becomes the window's top row, so only two rows are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mid <= '0;
            r_bot <= '0;
        end else if (w_complete) begin
            r_mid <= r_bot;
            r_bot <= w_row_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_data  <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_emit) begin
            r_win_data  <= {r_mid, r_bot, w_row_full};
            r_win_valid <= 1'b1;
            r_win_last  <= pix_last;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (w_err) begin
            r_frame_err <= 1'b1;
        end
    end

    assign win_data  = r_win_data;
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_cbs_line_buffer.sv
// Directed bench for cbs_line_buffer: windows, backpressure, frame end, errors, reset.
module tb_cbs_line_buffer;
    import cbs_pkg::*;

    logic clk = 1'b0;
    logic rst, pix_valid, pix_last, pix_ready;
    logic win_valid, win_last, win_ready, frame_err;
    pix_t pix_data;
    win_t win_data;

    int checks = 0;
    int errors = 0;
    win_t q_win[$];
    logic q_last[$];

    always #5 clk = ~clk;

    cbs_line_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_last  (win_last),
        .win_ready (win_ready),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (win_valid === 1'b1 && win_ready === 1'b1) begin
            q_win.push_back(win_data);
            q_last.push_back(win_last);
        end
    end

    function automatic win_t mkwin(input int a, input int b, input int c);
        win_t w;
        int base;
        w = '0;
        for (int k = 0; k < 3; k++) begin
            base = (k == 0) ? a : (k == 1) ? b : c;
            for (int i = 0; i < ROW_PIX; i++)
                w[WIN_W-1-(k*ROW_PIX+i)*PIX_W -: PIX_W] = pix_t'(base + i);
        end
        return w;
    endfunction

    task automatic send(input int d, input logic last);
        int n;
        pix_data  = pix_t'(d);
        pix_last  = last;
        pix_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pix_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: pix_ready=%b for pixel %0d, required 1", pix_ready, d);
                break;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_range(input int first, input int count, input logic last_on_final);
        for (int i = 0; i < count; i++)
            send(first + i, last_on_final && (i == count - 1));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0; win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b, required 0", win_valid); end
        checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL reset_win_last: got %b, required 0", win_last); end
        checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h, required 0", win_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b, required 1", pix_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_window();
        win_t exp;
        exp = mkwin(0, 10, 20);
        q_win.delete(); q_last.delete();
        send_range(0, 29, 1'b0);
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b, required 0", win_valid); end
        send(29, 1'b0);
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b, required 1", win_valid); end
        checks++; if (win_data[239:232] !== 8'd0) begin errors++; $display("FAIL first_msb_pix: got %0d, required 0", win_data[239:232]); end
        checks++; if (win_data[7:0] !== 8'd29) begin errors++; $display("FAIL first_lsb_pix: got %0d, required 29", win_data[7:0]); end
        checks++; if (win_data !== exp) begin errors++; $display("FAIL first_data: got %h, required %h", win_data, exp); end
        checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL first_last: got %b, required 0", win_last); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL first_pix_ready: got %b, required 1", pix_ready); end
        settle();
        checks++; if (q_win.size() !== 1) begin errors++; $display("FAIL first_count: got %0d windows, required 1", q_win.size()); end
    endtask

    task automatic test_second_window();
        win_t exp;
        exp = mkwin(10, 20, 30);
        q_win.delete(); q_last.delete();
        send_range(30, 10, 1'b0);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL second_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL second_data: got %h, required %h", q_win[0], exp); end
            checks++; if (q_last[0] !== 1'b0) begin errors++; $display("FAIL second_last: got %b, required 0", q_last[0]); end
        end
    endtask

    task automatic test_backpressure();
        win_t exp, exp2;
        exp  = mkwin(20, 30, 40);
        exp2 = mkwin(30, 40, 50);
        q_win.delete(); q_last.delete();
        win_ready = 1'b0;
        send_range(40, 10, 1'b0);
        pix_valid = 1'b1; pix_data = pix_t'(50); pix_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL stall_pix_ready: cycle %0d got %b, required 0", c, pix_ready); end
            checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL stall_win_valid: cycle %0d got %b, required 1", c, win_valid); end
            checks++; if (win_data !== exp) begin errors++; $display("FAIL stall_win_data: cycle %0d got %h, required %h", c, win_data, exp); end
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
        send(50, 1'b0);
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b, required 0", win_valid); end
        checks++; if (q_win.size() !== 1) begin errors++; $display("FAIL release_count: got %0d windows, required 1", q_win.size()); end
        send_range(51, 9, 1'b0);
        settle();
        checks++;
        if (q_win.size() !== 2) begin errors++; $display("FAIL resume_count: got %0d windows, required 2", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL release_data: got %h, required %h", q_win[0], exp); end
            checks++; if (q_win[1] !== exp2) begin errors++; $display("FAIL resume_data: got %h, required %h", q_win[1], exp2); end
        end
    endtask

    task automatic test_frame_last();
        win_t exp, exp2;
        exp  = mkwin(40, 50, 60);
        exp2 = mkwin(70, 80, 90);
        q_win.delete(); q_last.delete();
        send_range(60, 10, 1'b1);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL last_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL last_data: got %h, required %h", q_win[0], exp); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL last_flag: got %b, required 1", q_last[0]); end
        end
        q_win.delete(); q_last.delete();
        send_range(70, 29, 1'b0);
        settle();
        checks++; if (q_win.size() !== 0) begin errors++; $display("FAIL newframe_early: got %0d windows, required 0", q_win.size()); end
        send(99, 1'b0);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL newframe_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp2) begin errors++; $display("FAIL newframe_data: got %h, required %h", q_win[0], exp2); end
            checks++; if (q_last[0] !== 1'b0) begin errors++; $display("FAIL newframe_last: got %b, required 0", q_last[0]); end
        end
    endtask

    task automatic test_frame_err();
        win_t exp;
        exp = mkwin(110, 120, 130);
        q_win.delete(); q_last.delete();
        send_range(100, 5, 1'b1);
        settle();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b, required 1", frame_err); end
        checks++; if (q_win.size() !== 0) begin errors++; $display("FAIL err_no_window: got %0d windows, required 0", q_win.size()); end
        send_range(110, 29, 1'b0);
        settle();
        checks++; if (q_win.size() !== 0) begin errors++; $display("FAIL err_early: got %0d windows, required 0", q_win.size()); end
        send(139, 1'b0);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL err_recover_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL err_recover_data: got %h, required %h", q_win[0], exp); end
        end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", frame_err); end
    endtask

    task automatic test_reset_mid_row();
        win_t exp;
        exp = mkwin(160, 170, 180);
        send_range(140, 15, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_win_valid: got %b, required 0", win_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
        checks++; if (win_data !== '0) begin errors++; $display("FAIL rst_win_data: got %h, required 0", win_data); end
        q_win.delete(); q_last.delete();
        send_range(160, 29, 1'b0);
        settle();
        checks++; if (q_win.size() !== 0) begin errors++; $display("FAIL rst_early: got %0d windows, required 0", q_win.size()); end
        send(189, 1'b1);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL rst_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL rst_data: got %h, required %h", q_win[0], exp); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL rst_last: got %b, required 1", q_last[0]); end
        end
    endtask

    task automatic test_short_frame();
        win_t exp;
        exp = mkwin(210, 220, 230);
        q_win.delete(); q_last.delete();
        send_range(190, 20, 1'b1);
        settle();
        checks++; if (q_win.size() !== 0) begin errors++; $display("FAIL short_no_window: got %0d windows, required 0", q_win.size()); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_frame_err: got %b, required 0", frame_err); end
        send_range(210, 30, 1'b0);
        settle();
        checks++;
        if (q_win.size() !== 1) begin errors++; $display("FAIL short_next_count: got %0d windows, required 1", q_win.size()); end
        else begin
            checks++; if (q_win[0] !== exp) begin errors++; $display("FAIL short_next_data: got %h, required %h", q_win[0], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_second_window();
        test_backpressure();
        test_frame_last();
        test_frame_err();
        test_reset_mid_row();
        test_short_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
